// File: rtl/vrc_seq.sv
// vrc_seq: round-robin shot sequencer feeding the vrc curve generator.
// Optional per-channel window decimation: define VRC_SEQ_DECIM_EN.
module vrc_seq #(
  parameter int CH_NUM = 4,
  parameter int CH_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_trig,
  input  logic            i_cfg_we,
  input  logic [CH_W-1:0] i_cfg_ch,
  input  logic [2:0]      i_cfg_addr,
  input  logic [19:0]     i_cfg_data,
  output logic            o_sync,
  output logic            o_process,
  output logic [10:0]     o_start_amp,
  output logic [9:0]      o_amp_porch,
  output logic [19:0]     o_ainc_one,
  output logic [19:0]     o_ainc_two,
  output logic [15:0]     o_vrc_len,
  output logic [CH_W-1:0] o_ch,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_trig_miss
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SYNC, DELAY, RUN, DONE
  } state_t;

  localparam logic [CH_W:0] CH_LIM =
    (CH_W+1)'(CH_NUM);
  localparam logic [CH_W-1:0] CH_LAST =
    CH_W'(CH_NUM - 1);

  state_t state, state_nx;

  logic [10:0] b_amp [CH_NUM];
  logic [9:0]  b_por [CH_NUM];
  logic [19:0] b_ai1 [CH_NUM];
  logic [19:0] b_ai2 [CH_NUM];
  logic [15:0] b_len [CH_NUM];
  logic [15:0] b_dly [CH_NUM];
  logic [15:0] b_win [CH_NUM];

  logic [15:0] dly_cnt;
  logic [15:0] win_cnt;
  logic        miss_q;
  logic        wr_ok;

  assign wr_ok = i_cfg_we &&
                 ({1'b0, i_cfg_ch} < CH_LIM);

`ifdef VRC_SEQ_DECIM_EN
  logic [7:0] b_dec [CH_NUM];
  logic [7:0] sh_dec;
  logic [7:0] ph;
`endif

  // Config bank: writes land at any time, out-of-range ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        b_amp[i] <= '0;
        b_por[i] <= '0;
        b_ai1[i] <= '0;
        b_ai2[i] <= '0;
        b_len[i] <= '0;
        b_dly[i] <= '0;
        b_win[i] <= '0;
`ifdef VRC_SEQ_DECIM_EN
        b_dec[i] <= '0;
`endif
      end
    end else if (wr_ok) begin
      case (i_cfg_addr)
        3'd0: b_amp[i_cfg_ch] <= i_cfg_data[10:0];
        3'd1: b_por[i_cfg_ch] <= i_cfg_data[9:0];
        3'd2: b_ai1[i_cfg_ch] <= i_cfg_data;
        3'd3: b_ai2[i_cfg_ch] <= i_cfg_data;
        3'd4: b_len[i_cfg_ch] <= i_cfg_data[15:0];
        3'd5: b_dly[i_cfg_ch] <= i_cfg_data[15:0];
        3'd6: b_win[i_cfg_ch] <= i_cfg_data[15:0];
`ifdef VRC_SEQ_DECIM_EN
        3'd7: b_dec[i_cfg_ch] <= i_cfg_data[7:0];
`endif
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; counters hold the cycles still to go.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (i_trig) state_nx = LOAD;
      LOAD:  state_nx = SYNC;
      SYNC: begin
        if (dly_cnt != '0)      state_nx = DELAY;
        else if (win_cnt != '0) state_nx = RUN;
        else                    state_nx = DONE;
      end
      DELAY: begin
        if (dly_cnt == 16'd1)
          state_nx = (win_cnt != '0) ? RUN : DONE;
      end
      RUN:   if (win_cnt == 16'd1) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shadow load, counters, channel rotation, miss flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_start_amp <= '0;
      o_amp_porch <= '0;
      o_ainc_one  <= '0;
      o_ainc_two  <= '0;
      o_vrc_len   <= '0;
      o_ch        <= '0;
      dly_cnt     <= '0;
      win_cnt     <= '0;
      miss_q      <= 1'b0;
    end else begin
      miss_q <= i_trig && (state != IDLE);
      unique case (state)
        LOAD: begin
          o_start_amp <= b_amp[o_ch];
          o_amp_porch <= b_por[o_ch];
          o_ainc_one  <= b_ai1[o_ch];
          o_ainc_two  <= b_ai2[o_ch];
          o_vrc_len   <= b_len[o_ch];
          dly_cnt     <= b_dly[o_ch];
          win_cnt     <= b_win[o_ch];
        end
        DELAY: dly_cnt <= dly_cnt - 16'd1;
        RUN:   win_cnt <= win_cnt - 16'd1;
        DONE: begin
          if (o_ch == CH_LAST) o_ch <= '0;
          else                 o_ch <= o_ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef VRC_SEQ_DECIM_EN
  // Decimation phase: pulse on RUN entry, then every decim+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dec <= '0;
      ph     <= '0;
    end else begin
      if (state == LOAD) sh_dec <= b_dec[o_ch];
      if (state != RUN)     ph <= '0;
      else if (ph == sh_dec) ph <= '0;
      else                  ph <= ph + 8'd1;
    end
  end

  assign o_process = (state == RUN) && (ph == '0);
`else
  assign o_process = (state == RUN);
`endif

  assign o_sync      = (state == SYNC);
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
  assign o_trig_miss = miss_q;

endmodule

// File: tb/tb_vrc_seq.sv
// tb_vrc_seq: table vectors, random shots vs a waveform model,
// mid-shot reset and (when built with it) decimation.
`timescale 1ns/1ps
module tb_vrc_seq;
  localparam int CH_NUM = 4;
  localparam int CH_W   = 2;
`ifdef VRC_SEQ_DECIM_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_trig = 1'b0;
  logic            i_cfg_we = 1'b0;
  logic [CH_W-1:0] i_cfg_ch = '0;
  logic [2:0]      i_cfg_addr = '0;
  logic [19:0]     i_cfg_data = '0;
  logic            o_sync, o_process;
  logic [10:0]     o_start_amp;
  logic [9:0]      o_amp_porch;
  logic [19:0]     o_ainc_one, o_ainc_two;
  logic [15:0]     o_vrc_len;
  logic [CH_W-1:0] o_ch;
  logic            o_busy, o_done, o_trig_miss;

  vrc_seq #(.CH_NUM(CH_NUM), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_trig(i_trig),
    .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch),
    .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
    .o_sync(o_sync), .o_process(o_process),
    .o_start_amp(o_start_amp),
    .o_amp_porch(o_amp_porch),
    .o_ainc_one(o_ainc_one), .o_ainc_two(o_ainc_two),
    .o_vrc_len(o_vrc_len), .o_ch(o_ch),
    .o_busy(o_busy), .o_done(o_done),
    .o_trig_miss(o_trig_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d; int w; int amp;
    int trig_t; int wr_t;
    int e_done; int e_first; int e_cnt; int e_miss;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [19:0] m_bank [CH_NUM][8];
  int m_ch;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] fmask(
      input int a, input logic [19:0] d);
    case (a)
      0: return {9'b0, d[10:0]};
      1: return {10'b0, d[9:0]};
      2, 3: return d;
      4, 5, 6: return {4'b0, d[15:0]};
      7: return DEC ? {12'b0, d[7:0]} : 20'b0;
      default: return 20'b0;
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < CH_NUM; c++)
      for (int a = 0; a < 8; a++) m_bank[c][a] = '0;
    m_ch = 0;
  endtask

  // Expected {sync, process, done, busy} t cycles after trigger.
  function automatic logic [3:0] ectl(
      input int t, input int d, input int w, input int dc);
    int L;
    logic p;
    L = 3 + d + w;
    p = (t >= 3 + d) && (t < 3 + d + w) &&
        (((t - 3 - d) % (dc + 1)) == 0);
    return {t == 2, p, t == L, (t >= 1) && (t <= L)};
  endfunction

  task automatic cfg(input int ch, input int a,
                     input logic [19:0] d);
    @(negedge clk);
    i_cfg_we = 1'b1;
    i_cfg_ch = CH_W'(ch);
    i_cfg_addr = 3'(a);
    i_cfg_data = d;
    @(negedge clk);
    i_cfg_we = 1'b0;
    if (ch < CH_NUM) m_bank[ch][a] = fmask(a, d);
  endtask

  task automatic shot(input int trig_t, input int wr_t,
                      input int wa, input logic [19:0] wd,
                      output int done_t, output int first_t,
                      output int pcnt, output int miss_t);
    logic [19:0] s [8];
    logic [76:0] esh;
    int c, nx, d, w, dc, L;
    logic em;
    c = m_ch;
    for (int k = 0; k < 8; k++) s[k] = m_bank[c][k];
    d = int'(s[5]);
    w = int'(s[6]);
    dc = DEC ? int'(s[7]) : 0;
    L = 3 + d + w;
    nx = (c == CH_NUM - 1) ? 0 : c + 1;
    esh = {s[0][10:0], s[1][9:0], s[2], s[3], s[4][15:0]};
    done_t = -1; first_t = -1; pcnt = 0; miss_t = -1;
    @(negedge clk);
    chk("ch_pre", 128'(o_ch), 128'(c));
    i_trig = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= L + 1; t++) begin
      em = (trig_t >= 1) && (trig_t <= L) &&
           (t == trig_t + 1);
      chk("ctl", {o_sync, o_process, o_done, o_busy},
          ectl(t, d, w, dc));
      chk("miss", 128'(o_trig_miss), 128'(em));
      if (o_done) done_t = t;
      if (o_trig_miss) miss_t = t;
      if (o_process) begin
        pcnt++;
        if (first_t < 0) first_t = t;
      end
      if (t == 2 || t == L)
        chk("shadow", {o_start_amp, o_amp_porch,
                       o_ainc_one, o_ainc_two,
                       o_vrc_len}, esh);
      if (t == L + 1)
        chk("ch_post", 128'(o_ch), 128'(nx));
      i_trig = (t == trig_t) && (t <= L);
      i_cfg_we = (t == wr_t) && (t <= L);
      if (i_cfg_we) begin
        i_cfg_ch = CH_W'(c);
        i_cfg_addr = 3'(wa);
        i_cfg_data = wd;
        m_bank[c][wa] = fmask(wa, wd);
      end
      @(negedge clk);
    end
    i_trig = 1'b0;
    i_cfg_we = 1'b0;
    m_ch = nx;
  endtask

  initial begin
    vec_t tv [5];
    int dt, ft, pc, mt, a;
    logic [19:0] dd;
    m_reset();
    #1;
    chk("reset_outs",
        {o_sync, o_process, o_start_amp, o_amp_porch,
         o_ainc_one, o_ainc_two, o_vrc_len, o_ch,
         o_busy, o_done, o_trig_miss}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tv[0] = '{0, 0, 'h000, 0, 0,  3, -1,  0, -1};
    tv[1] = '{5, 10, 'h155, 0, 10, 18, 8, 10, -1};
    tv[2] = '{5, 3, 'h2AA, 4, 0, 11, 8,  3,  5};
    tv[3] = '{0, 4, 'h7FF, 0, 1,  7, 3,  4, -1};
    tv[4] = '{2, 0, 'h001, 5, 0,  5, -1, 0,  6};
    for (int i = 0; i < 5; i++) begin
      cfg(m_ch, 0, 20'(tv[i].amp));
      cfg(m_ch, 2, 20'(i * 'h11111));
      cfg(m_ch, 5, 20'(tv[i].d));
      cfg(m_ch, 6, 20'(tv[i].w));
      shot(tv[i].trig_t, tv[i].wr_t, 2,
           20'(20'hABCDE + i), dt, ft, pc, mt);
      chk("tv_done", 128'(dt), 128'(tv[i].e_done));
      chk("tv_first", 128'(ft), 128'(tv[i].e_first));
      chk("tv_cnt", 128'(pc), 128'(tv[i].e_cnt));
      chk("tv_miss", 128'(mt), 128'(tv[i].e_miss));
    end

    for (int n = 0; n < 24; n++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        a = $urandom_range(0, 7);
        if (a == 5 || a == 6) dd = 20'($urandom_range(0, 8));
        else if (a == 7) dd = 20'($urandom_range(0, 3));
        else dd = 20'($urandom);
        cfg($urandom_range(0, CH_NUM - 1), a, dd);
      end
      shot($urandom_range(0, 12), $urandom_range(0, 12),
           $urandom_range(0, 4), 20'($urandom),
           dt, ft, pc, mt);
    end

`ifdef VRC_SEQ_DECIM_EN
    cfg(m_ch, 7, 20'd3);
    cfg(m_ch, 5, 20'd0);
    cfg(m_ch, 6, 20'd8);
    a = m_ch;
    shot(0, 0, 0, 20'd0, dt, ft, pc, mt);
    chk("dec_first", 128'(ft), 128'(3));
    chk("dec_cnt", 128'(pc), 128'(2));
    cfg(a, 7, 20'd0);
`endif

    cfg(m_ch, 7, 20'd0);
    cfg(m_ch, 5, 20'd0);
    cfg(m_ch, 6, 20'd20);
    cfg(m_ch, 0, 20'h3FF);
    @(negedge clk);
    i_trig = 1'b1;
    @(negedge clk);
    i_trig = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_run", 128'(o_process), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst",
        {o_sync, o_process, o_start_amp, o_amp_porch,
         o_ainc_one, o_ainc_two, o_vrc_len, o_ch,
         o_busy, o_done, o_trig_miss}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    shot(0, 0, 0, 20'd0, dt, ft, pc, mt);
    chk("post_rst_done", 128'(dt), 128'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
